// File: rtl/psg_pkg.sv
// Shared PSG definitions: register map, envelope shape bit positions and the
// envelope restart sequencer state encoding.
package psg_pkg;

  // Envelope register addresses within the PSG register file
  localparam logic [3:0] ENV_FINE   = 4'd11;
  localparam logic [3:0] ENV_COARSE = 4'd12;
  localparam logic [3:0] ENV_SHAPE  = 4'd13;

  // Bit positions of the shape register fields
  localparam int SHAPE_CONT = 3;
  localparam int SHAPE_ATT  = 2;
  localparam int SHAPE_ALT  = 1;
  localparam int SHAPE_HOLD = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    SETTLE  = 2'd2
  } env_state_e;

endpackage : psg_pkg

// File: rtl/envelope_sequencer.sv
// Envelope register front end: decodes period/shape writes and issues a
// registered, glitch-free restart pulse to the envelope generator on shape writes.
module envelope_sequencer
  import psg_pkg::*;
#(
  parameter int         PERIOD_BITS    = 16,
  parameter int         RESTART_CYCLES = 2,
  parameter bit         ATOMIC_PERIOD  = 1'b1,
  parameter logic [3:0] FINE_ADDR      = ENV_FINE,
  parameter logic [3:0] COARSE_ADDR    = ENV_COARSE,
  parameter logic [3:0] SHAPE_ADDR     = ENV_SHAPE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [3:0]             addr,
  input  logic [7:0]             data,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   continue_,
  output logic                   attack,
  output logic                   alternate,
  output logic                   hold,
  output logic                   env_restart,
  output logic                   busy
);

  localparam int              CNT_BITS = $clog2(RESTART_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(RESTART_CYCLES - 1);

  logic                fine_wr;
  logic                coarse_wr;
  logic                shape_wr;

  logic [7:0]          fine_stage;
  logic                fine_pending;
  logic [3:0]          shape;

  env_state_e          state, state_next;
  logic [CNT_BITS-1:0] cnt, cnt_next;
  logic                restart_next;
  logic                busy_next;

  assign fine_wr   = we && (addr == FINE_ADDR);
  assign coarse_wr = we && (addr == COARSE_ADDR);
  assign shape_wr  = we && (addr == SHAPE_ADDR);

  assign continue_ = shape[SHAPE_CONT];
  assign attack    = shape[SHAPE_ATT];
  assign alternate = shape[SHAPE_ALT];
  assign hold      = shape[SHAPE_HOLD];

  // ---------------------------------------------------------------------------
  // Register datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period       <= '0;
      fine_stage   <= '0;
      fine_pending <= 1'b0;
      shape        <= '0;
    end else begin
      if (fine_wr) begin
        fine_stage <= data;
        if (ATOMIC_PERIOD) begin
          fine_pending <= 1'b1;
        end else begin
          period[7:0] <= data;
        end
      end

      if (coarse_wr) begin
        period[PERIOD_BITS-1:8] <= data[PERIOD_BITS-9:0];
        if (ATOMIC_PERIOD) begin
          period[7:0]  <= fine_stage;
          fine_pending <= 1'b0;
        end
      end

      // Shape bits only move on the edge that (re)enters RESTART.
      if (shape_wr) begin
        shape <= data[3:0];
        if (ATOMIC_PERIOD && fine_pending) begin
          period[7:0]  <= fine_stage;
          fine_pending <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Restart sequencer
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;

    unique case (state)
      IDLE: ;
      RESTART: begin
        if (cnt == '0) begin
          state_next = SETTLE;
        end else begin
          cnt_next = cnt - CNT_BITS'(1);
        end
      end
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A shape write in any state extends the pulse rather than splitting it.
    if (shape_wr) begin
      state_next = RESTART;
      cnt_next   = CNT_LOAD;
    end

    restart_next = (state_next == RESTART);
    busy_next    = (state_next != IDLE);
  end

  // Outputs are registered from next-state so env_restart comes straight off a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      env_restart <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      env_restart <= restart_next;
      busy        <= busy_next;
    end
  end

endmodule : envelope_sequencer

// File: tb/tb_envelope_sequencer.sv
// Directed self-checking bench for envelope_sequencer: default, 12-bit period
// and non-atomic period instances share one register-write bus.
module tb_envelope_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  data;

  logic [15:0] period;
  logic        continue_, attack, alternate, hold, env_restart, busy;

  logic [11:0] p12_period;
  logic        p12_cont, p12_att, p12_alt, p12_hold, p12_restart, p12_busy;

  logic [15:0] na_period;
  logic        na_cont, na_att, na_alt, na_hold, na_restart, na_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  envelope_sequencer dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .data(data),
    .period(period), .continue_(continue_), .attack(attack),
    .alternate(alternate), .hold(hold), .env_restart(env_restart), .busy(busy)
  );

  envelope_sequencer #(.PERIOD_BITS(12)) dut12 (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .data(data),
    .period(p12_period), .continue_(p12_cont), .attack(p12_att),
    .alternate(p12_alt), .hold(p12_hold), .env_restart(p12_restart), .busy(p12_busy)
  );

  envelope_sequencer #(.ATOMIC_PERIOD(1'b0)) dut_na (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .data(data),
    .period(na_period), .continue_(na_cont), .attack(na_att),
    .alternate(na_alt), .hold(na_hold), .env_restart(na_restart), .busy(na_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One register write; returns at the falling edge after the sampling edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; data = d;
    @(negedge clk);
    we = 1'b0; addr = '0; data = '0;
  endtask

  function automatic logic [3:0] shape_of();
    return {continue_, attack, alternate, hold};
  endfunction

  task automatic check_pulse(input string tag, input logic r, input logic b);
    check({tag, "_restart"}, 32'(env_restart), 32'(r));
    check({tag, "_busy"},    32'(busy),        32'(b));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    we = 1'b0; addr = '0; data = '0;
    do_reset();

    // Reset and idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_period", 32'(period), 32'h0);
      check("idle_shape",  32'(shape_of()), 32'h0);
      check_pulse("idle", 1'b0, 1'b0);
    end

    // Atomic period: fine staged until coarse
    wr(4'd11, 8'h34);
    check("fine_staged",     32'(period),    32'h0000);
    check("na_fine_direct",  32'(na_period), 32'h0034);
    check("p12_fine_staged", 32'(p12_period), 32'h000);
    wr(4'd12, 8'h12);
    check("coarse_commit",   32'(period),     32'h1234);
    check("p12_coarse",      32'(p12_period), 32'h234);
    check("na_coarse",       32'(na_period),  32'h1234);
    wr(4'd12, 8'hFF);
    check("coarse_ff",       32'(period),     32'hFF34);
    check("p12_coarse_trunc",32'(p12_period), 32'hF34);

    // Shape 0x0E: 2-cycle pulse then one settle cycle
    wr(4'd13, 8'h0E);
    check("shape_0e", 32'(shape_of()), 32'he);
    check_pulse("s0e_c0", 1'b1, 1'b1);
    @(negedge clk); check_pulse("s0e_c1", 1'b1, 1'b1);
    @(negedge clk); check_pulse("s0e_c2", 1'b0, 1'b1);
    @(negedge clk); check_pulse("s0e_c3", 1'b0, 1'b0);
    check("shape_0e_hold", 32'(shape_of()), 32'he);

    // Fine then shape commits the pending byte
    wr(4'd11, 8'h55);
    check("fine55_staged", 32'(period), 32'hFF34);
    wr(4'd13, 8'h09);
    check("shape_commit_period", 32'(period), 32'hFF55);
    check("shape_09", 32'(shape_of()), 32'h9);
    check_pulse("s09_c0", 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_pulse("s09_done", 1'b0, 1'b0);

    // Back-to-back shape writes: one 3-cycle pulse
    @(negedge clk);
    we = 1'b1; addr = 4'd13; data = 8'h00;
    @(negedge clk);
    check("b2b_first_shape", 32'(shape_of()), 32'h0);
    check_pulse("b2b_c0", 1'b1, 1'b1);
    data = 8'h0D;
    @(negedge clk);
    we = 1'b0; addr = '0; data = '0;
    check("b2b_c1_shape", 32'(shape_of()), 32'hd);
    check_pulse("b2b_c1", 1'b1, 1'b1);
    @(negedge clk);
    check("b2b_c2_shape", 32'(shape_of()), 32'hd);
    check_pulse("b2b_c2", 1'b1, 1'b1);
    @(negedge clk);
    check_pulse("b2b_c3", 1'b0, 1'b1);
    @(negedge clk);
    check_pulse("b2b_c4", 1'b0, 1'b0);

    // Reset mid-pulse clears outputs asynchronously
    wr(4'd13, 8'h0F);
    check_pulse("pre_rst", 1'b1, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_pulse("async_rst", 1'b0, 1'b0);
    check("async_rst_period", 32'(period), 32'h0);
    check("async_rst_shape",  32'(shape_of()), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Non-atomic immediate fine; unmapped address ignored
    wr(4'd11, 8'hA5);
    check("na_fine_a5",   32'(na_period), 32'h00A5);
    check("atomic_fine_a5", 32'(period),  32'h0000);
    wr(4'd7, 8'hFF);
    check("addr7_na_period", 32'(na_period), 32'h00A5);
    check("addr7_na_shape",  32'({na_cont, na_att, na_alt, na_hold}), 32'h0);
    check("addr7_na_restart", 32'({na_restart, na_busy}), 32'h0);
    check("addr7_period", 32'(period), 32'h0000);
    check("addr7_shape",  32'(shape_of()), 32'h0);
    check_pulse("addr7", 1'b0, 1'b0);
    @(negedge clk);
    check("addr7_later_busy", 32'({na_busy, busy, p12_busy}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_envelope_sequencer
